hsc_ddr2_local_slave: RTL

Synthesizable responder for the DDR2 controller local interface, backed by on-chip RAM. It accepts the same burst write and read traffic that the DDR2 FIFO controller issues, so that controller and its user ports can be brought up on FPGA or in simulation without the DDR2 IP or memory. It sits in place of the DDR2 controller and drives `local_ready`, `local_rdata`, `local_rdata_valid` and `local_init_done`.

---
 rtl/hsc_ddr2_pkg.sv | 23 ++
 rtl/hsc_ddr2_model_ram.sv | 42 ++++
 rtl/hsc_ddr2_local_slave.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hsc_ddr2_pkg.sv
// hsc_ddr2_pkg
// Shared definitions for the DDR2 local-interface model. The FIFO
// controller and the local slave both use these definitions.
// Contents:
//   BURST_LEN_W     - width of the burst_len field (beats per burst)
//   INIT_CYCLES_DEF - default power-up calibration delay in clk cycles
//   RD_LAT_DEF      - default read latency, request sample to first data
//   state_t         - local slave FSM states
package hsc_ddr2_pkg;

    localparam int BURST_LEN_W     = 7;
    localparam int INIT_CYCLES_DEF = 200;
    localparam int RD_LAT_DEF      = 4;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_DATA
    } state_t;

endpackage

// File: rtl/hsc_ddr2_model_ram.sv
// hsc_ddr2_model_ram
// Simple dual-port RAM, DATA_W x 2^AW. It has one write port and one
// registered read port, and both ports use the same clock. The array is
// not reset, so synthesis can map it onto block RAM.
// Ports:
//   clk     - clock for both ports
//   wr_en   - write strobe
//   wr_addr - write index
//   wr_data - write data
//   rd_addr - read index, sampled every clock
//   rd_data - data read at the previous edge
module hsc_ddr2_model_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    logic [DATA_W-1:0] rd_data_q;

    // Write port: one word per cycle when strobed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: reads unconditionally every cycle. It has no reset, so
    // the block RAM output register can absorb it.
    always_ff @(posedge clk) begin
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/hsc_ddr2_local_slave.sv
// hsc_ddr2_local_slave
// Stand-in for the DDR2 controller local interface, backed by on-chip RAM.
// It accepts burst writes (one beat per local_ready cycle) and burst reads
// (data returns RD_LAT cycles after the request is sampled).
// Ports:
//   clk, rst_n        - clock; asynchronous active-low reset
//   burst_len         - beats per burst, sampled at burst start (0 => 1)
//   local_address     - burst base address, held for the whole burst
//   local_write_req   - write beat request
//   local_wdata       - write beat data
//   local_read_req    - read burst request
//   local_ready       - high while a write burst is open
//   local_rdata       - read data, zero when not valid
//   local_rdata_valid - read data qualifier
//   local_init_done   - high once the power-up delay has elapsed
//   proto_err         - sticky: a request of the other type arrived mid-burst
module hsc_ddr2_local_slave
    import hsc_ddr2_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int RD_LAT      = RD_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BURST_LEN_W-1:0] burst_len,
    input  logic [ADDR_W-1:0]      local_address,
    input  logic                   local_write_req,
    input  logic [DATA_W-1:0]      local_wdata,
    input  logic                   local_read_req,
    output logic                   local_ready,
    output logic [DATA_W-1:0]      local_rdata,
    output logic                   local_rdata_valid,
    output logic                   local_init_done,
    output logic                   proto_err
);

    localparam int CNT_W = 16;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BURST_LEN_W-1:0] beat_q, beat_d;
    logic [BURST_LEN_W-1:0] blen_q, blen_d;
    logic [MEM_AW-1:0]      base_q, base_d;
    logic                   proto_err_q, proto_err_d;

    logic [BURST_LEN_W-1:0] start_len;
    logic                   last_beat;
    logic                   ram_we;
    logic [MEM_AW-1:0]      ram_waddr;
    logic [MEM_AW-1:0]      ram_raddr;
    logic [DATA_W-1:0]      ram_rdata;
    logic                   addr_hi_unused;

    // The low MEM_AW bits of (base + beat) mod 2^ADDR_W depend only on the
    // low bits of base. Only those bits are kept, and the sum wraps at the
    // top of the RAM.
    assign addr_hi_unused = ^local_address[ADDR_W-1:MEM_AW];

    assign start_len = (burst_len == '0) ? BURST_LEN_W'(1) : burst_len;
    assign last_beat = (beat_q == blen_q - BURST_LEN_W'(1));

    // The read index runs one beat ahead once data is flowing. The RAM
    // output register then presents beat i during the cycle in which beat i
    // is valid. During RD_WAIT the index sits on beat 0.
    assign ram_waddr = base_q + MEM_AW'(beat_q);
    assign ram_raddr = base_q + MEM_AW'(beat_q)
                     + ((state_q == ST_RD_DATA) ? MEM_AW'(1) : '0);

    // State register and burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            beat_q      <= '0;
            blen_q      <= BURST_LEN_W'(1);
            base_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            blen_q      <= blen_d;
            base_q      <= base_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state logic. cnt is shared between the init delay and the read
    // wait, because those two phases never overlap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        blen_d      = blen_q;
        base_d      = base_q;
        proto_err_d = proto_err_q;
        ram_we      = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                if (local_write_req) begin
                    base_d  = local_address[MEM_AW-1:0];
                    blen_d  = start_len;
                    beat_d  = '0;
                    state_d = ST_WR;
                end else if (local_read_req) begin
                    base_d  = local_address[MEM_AW-1:0];
                    blen_d  = start_len;
                    beat_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_RD_WAIT;
                end
            end

            ST_WR: begin
                if (local_read_req) begin
                    proto_err_d = 1'b1;
                end
                if (local_write_req) begin
                    ram_we = 1'b1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BURST_LEN_W'(1);
                    end
                end
            end

            ST_RD_WAIT: begin
                if (local_write_req) begin
                    proto_err_d = 1'b1;
                end
                if (cnt_q == CNT_W'(RD_LAT - 2)) begin
                    state_d = ST_RD_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RD_DATA: begin
                if (local_write_req) begin
                    proto_err_d = 1'b1;
                end
                if (last_beat) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + BURST_LEN_W'(1);
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    hsc_ddr2_model_ram #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (local_wdata),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    // All outputs decode registered state, so reset clears them at once.
    assign local_ready       = (state_q == ST_WR);
    assign local_rdata_valid = (state_q == ST_RD_DATA);
    assign local_rdata       = local_rdata_valid ? ram_rdata : '0;
    assign local_init_done   = (state_q != ST_INIT);
    assign proto_err         = proto_err_q;

endmodule
